// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: synchronises and filters the raw lines, frames each
// 11-bit character and folds E0/F0/E1 prefixes into a toggling ps2_key event.
module ps2_key_encoder #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 24000
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        err,
  output logic        busy
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Index 0 is the PS/2 clock line, index 1 the data line.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_prev;
  logic          fall;

  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic          stop_bit;
  logic          frame_done;
  logic [TW-1:0] idle_cnt;
  logic          timeout_hit;
  logic          frame_ok;
  logic          byte_valid;
  logic          frame_bad;

  logic          ext;
  logic          rel;
  logic [2:0]    skip_cnt;

  assign raw = {ps2_dat_in, ps2_clk_in};

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // sample the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1    <= '1;
      sync2    <= '1;
      filt     <= '1;
      fcnt     <= '{default: '0};
      clk_prev <= 1'b1;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      clk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall        = clk_prev & ~filt[0];
  assign busy        = (bit_cnt != 4'd0);
  assign timeout_hit = busy && (idle_cnt == TW'(TIMEOUT - 1));
  assign frame_ok    = (^{shift, parity_bit}) & stop_bit;
  assign byte_valid  = frame_done & frame_ok;
  assign frame_bad   = frame_done & ~frame_ok;

  // bit_cnt holds the index of the next expected bit; 0 means idle.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      parity_bit <= 1'b0;
      stop_bit   <= 1'b0;
      frame_done <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (fall || !busy) idle_cnt <= '0;
      else               idle_cnt <= idle_cnt + 1'b1;

      if (timeout_hit) begin
        bit_cnt <= 4'd0;
      end else if (fall) begin
        case (bit_cnt)
          4'd0: if (!filt[1]) bit_cnt <= 4'd1;
          4'd9: begin
            parity_bit <= filt[1];
            bit_cnt    <= 4'd10;
          end
          4'd10: begin
            stop_bit   <= filt[1];
            bit_cnt    <= 4'd0;
            frame_done <= 1'b1;
          end
          default: begin
            shift   <= {filt[1], shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        endcase
      end
    end
  end

  // A bad frame or a timeout discards any pending prefix, so a stray F0 or E1
  // cannot corrupt the next good key.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      ps2_key  <= 11'h000;
      err      <= 1'b0;
      ext      <= 1'b0;
      rel      <= 1'b0;
      skip_cnt <= 3'd0;
    end else begin
      err <= frame_bad | timeout_hit;
      if (frame_bad || timeout_hit) begin
        ext      <= 1'b0;
        rel      <= 1'b0;
        skip_cnt <= 3'd0;
      end else if (byte_valid) begin
        if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 1'b1;
        end else if (shift == 8'hE1) begin
          skip_cnt <= 3'd7;
        end else if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift == 8'hF0) begin
          rel <= 1'b1;
        end else begin
          ps2_key <= {~ps2_key[10], ~rel, ext, shift};
          ext     <= 1'b0;
          rel     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: bit-banged PS/2 frames from a vector
// table plus hand-written latency, timeout, glitch and reset sequences.
module tb_ps2_key_encoder;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 20;

  logic        clk_sys    = 1'b0;
  logic        RESET_N    = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;
  logic [10:0] ps2_key;
  logic        err;
  logic        busy;

  ps2_key_encoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys    (clk_sys),
    .RESET_N    (RESET_N),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_key    (ps2_key),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  code;
    logic        par_bad;
    logic        stop_bad;
    logic [10:0] exp_key;
    int          exp_err;
  } vec_t;

  vec_t        vecs [22];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          err_seen  = 0;
  int          err_wide  = 0;
  int          err_clash = 0;
  logic        err_q     = 1'b0;
  logic [10:0] key_q     = 11'h000;

  // err must be a single-cycle pulse and never coincide with a key event.
  always @(negedge clk_sys) begin
    if (err) err_seen++;
    if (err && err_q) err_wide++;
    if (err && (ps2_key !== key_q)) err_clash++;
    err_q <= err;
    key_q <= ps2_key;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    ps2_dat_in = b;
    tick(HALF);
    ps2_clk_in = 1'b0;
    tick(HALF);
    ps2_clk_in = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] code, input logic par_bad,
                                             input logic stop_bad);
    return {~stop_bad, (~^code) ^ par_bad, code, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] code, input logic par_bad, input logic stop_bad);
    logic [10:0] f;
    f = frame_bits(code, par_bad, stop_bad);
    for (int i = 0; i < 11; i++) drive_bit(f[i]);
    tick(HALF);
  endtask

  initial begin
    logic [10:0] f;
    int          e0;

    vecs[0]  = '{8'hF0, 1'b0, 1'b0, 11'h629, 0};
    vecs[1]  = '{8'h29, 1'b0, 1'b0, 11'h029, 0};
    vecs[2]  = '{8'hE0, 1'b0, 1'b0, 11'h029, 0};
    vecs[3]  = '{8'h75, 1'b0, 1'b0, 11'h775, 0};
    vecs[4]  = '{8'hE0, 1'b0, 1'b0, 11'h775, 0};
    vecs[5]  = '{8'hF0, 1'b0, 1'b0, 11'h775, 0};
    vecs[6]  = '{8'h75, 1'b0, 1'b0, 11'h175, 0};
    vecs[7]  = '{8'hF0, 1'b0, 1'b0, 11'h175, 0};
    vecs[8]  = '{8'h1C, 1'b1, 1'b0, 11'h175, 1};
    vecs[9]  = '{8'h1C, 1'b0, 1'b0, 11'h61C, 0};
    vecs[10] = '{8'hE1, 1'b0, 1'b0, 11'h61C, 0};
    vecs[11] = '{8'h14, 1'b0, 1'b0, 11'h61C, 0};
    vecs[12] = '{8'h77, 1'b0, 1'b0, 11'h61C, 0};
    vecs[13] = '{8'hE1, 1'b0, 1'b0, 11'h61C, 0};
    vecs[14] = '{8'hF0, 1'b0, 1'b0, 11'h61C, 0};
    vecs[15] = '{8'h14, 1'b0, 1'b0, 11'h61C, 0};
    vecs[16] = '{8'hF0, 1'b0, 1'b0, 11'h61C, 0};
    vecs[17] = '{8'h77, 1'b0, 1'b0, 11'h61C, 0};
    vecs[18] = '{8'h05, 1'b0, 1'b0, 11'h205, 0};
    vecs[19] = '{8'hE0, 1'b0, 1'b0, 11'h205, 0};
    vecs[20] = '{8'h33, 1'b0, 1'b1, 11'h205, 1};
    vecs[21] = '{8'h33, 1'b0, 1'b0, 11'h633, 0};

    tick(5);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_err", 32'(err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    RESET_N = 1'b1;
    tick(HALF);

    // First make code 29: event lands FILTER+4 clocks after the stop-bit clock
    // drop (2 sync + FILTER filter + stop capture + event register).
    f = frame_bits(8'h29, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_bit(f[i]);
      if (i == 5) check("busy_mid_frame", 32'(busy), 32'h1);
    end
    ps2_dat_in = 1'b1;
    tick(HALF);
    ps2_clk_in = 1'b0;
    tick(FILTER + 3);
    check("make29_early", 32'(ps2_key), 32'h000);
    tick(1);
    check("make29_event", 32'(ps2_key), 32'h629);
    tick(HALF - FILTER - 4);
    ps2_clk_in = 1'b1;
    tick(HALF);
    check("make29_busy", 32'(busy), 32'h0);
    check("make29_err", 32'(err_seen), 32'h0);

    // A clock pulse with data high is not a start bit.
    e0 = err_seen;
    drive_bit(1'b1);
    tick(HALF);
    check("bad_start_busy", 32'(busy), 32'h0);
    check("bad_start_err", 32'(err_seen - e0), 32'h0);

    for (int i = 0; i < 22; i++) begin
      e0 = err_seen;
      send_frame(vecs[i].code, vecs[i].par_bad, vecs[i].stop_bad);
      check($sformatf("vec%0d_key", i), 32'(ps2_key), 32'(vecs[i].exp_key));
      check($sformatf("vec%0d_err", i), 32'(err_seen - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
    end

    // Timeout after 5 bits drops the partial byte and the pending F0.
    send_frame(8'hF0, 1'b0, 1'b0);
    check("to_f0_key", 32'(ps2_key), 32'h633);
    f = frame_bits(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_bit(f[i]);
    check("to_busy_before", 32'(busy), 32'h1);
    e0 = err_seen;
    tick(TIMEOUT + HALF);
    check("to_err", 32'(err_seen - e0), 32'h1);
    check("to_busy_after", 32'(busy), 32'h0);
    send_frame(8'h16, 1'b0, 1'b0);
    check("to_next_key", 32'(ps2_key), 32'h216);

    // A FILTER-1 cycle low glitch with data low must not start a frame.
    ps2_dat_in = 1'b0;
    ps2_clk_in = 1'b0;
    tick(FILTER - 1);
    ps2_clk_in = 1'b1;
    tick(HALF);
    check("glitch_busy", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("glitch_next_key", 32'(ps2_key), 32'h65A);

    // Reset mid-frame, then a fresh frame decodes from scratch.
    f = frame_bits(8'h29, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(f[i]);
    RESET_N = 1'b0;
    tick(3);
    check("midrst_key", 32'(ps2_key), 32'h000);
    check("midrst_busy", 32'(busy), 32'h0);
    RESET_N = 1'b1;
    tick(HALF);
    send_frame(8'h29, 1'b0, 1'b0);
    check("midrst_next_key", 32'(ps2_key), 32'h629);

    check("err_total", 32'(err_seen), 32'h3);
    check("err_width", 32'(err_wide), 32'h0);
    check("err_event_clash", 32'(err_clash), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
